// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: state encodings and constants.
package instruction_fetch_pkg;

  // Fetch-stage run state, visible to the debug unit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } if_state_e;

  // All-zero word injected into IF/ID on halt and flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instruction_fetch_instr_memory.sv
// Instruction memory: synchronous write port for program load, combinational read.
// Contents are deliberately not reset so a loaded program survives a pipeline reset.
module instr_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Program-load write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register, run-state FSM and
// program-load port. Halt > stall > flush > normal fetch inside RUN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int N_ADDR_BITS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_start,
  input  logic                   i_load_valid,
  input  logic [N_ADDR_BITS-1:0] i_load_addr,
  input  logic [N_BITS-1:0]      i_load_data,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [N_BITS-1:0]      i_jump_direction,
  input  logic                   i_halt,
  output logic [N_BITS-1:0]      o_instruccion,
  output logic [N_BITS-1:0]      o_pc_4,
  output logic [N_BITS-1:0]      o_pc,
  output logic [1:0]             o_state
);

  localparam logic [N_BITS-1:0] NOP_W  = N_BITS'(NOP_INSTR);
  localparam logic [N_BITS-1:0] STEP_W = N_BITS'(PC_STEP);
  localparam logic [N_BITS-1:0] ZERO_W = {N_BITS{1'b0}};

  if_state_e         state_q, state_d;
  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] instr_q, instr_d;
  logic [N_BITS-1:0] pc4_q, pc4_d;

  logic [N_BITS-1:0] pc_plus4_s;
  logic [N_BITS-1:0] rd_data_s;
  logic              mem_we_s;

  // Loads are only honoured while idle; the debug enable does not gate them.
  assign mem_we_s   = i_load_valid && (state_q == ST_IDLE);
  // Wraps naturally at the top of the address space.
  assign pc_plus4_s = pc_q + STEP_W;

  instr_memory #(
    .DATA_W (N_BITS),
    .ADDR_W (N_ADDR_BITS)
  ) u_instr_memory (
    .i_clk   (i_clk),
    .i_we    (mem_we_s),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (pc_q[N_ADDR_BITS+1:2]),
    .o_rdata (rd_data_s)
  );

  // Next-state for FSM, PC and IF/ID; everything holds while disabled.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (i_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            state_d = ST_HALTED;
            instr_d = NOP_W;
            pc4_d   = ZERO_W;
          end else if (i_stall) begin
            // Branch is re-resolved after the stall, so flush is not taken here.
            state_d = ST_RUN;
          end else if (i_flush) begin
            pc_d    = i_jump_direction;
            instr_d = NOP_W;
            pc4_d   = ZERO_W;
          end else begin
            instr_d = rd_data_s;
            pc4_d   = pc_plus4_s;
            pc_d    = pc_plus4_s;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ZERO_W;
      instr_q <= NOP_W;
      pc4_q   <= ZERO_W;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_instruccion = instr_q;
  assign o_pc_4        = pc4_q;
  assign o_pc          = pc_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_start;
  logic        i_load_valid;
  logic [7:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_jump_direction;
  logic        i_halt;
  logic [31:0] o_instruccion;
  logic [31:0] o_pc_4;
  logic [31:0] o_pc;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] w [0:10];

  instruction_fetch #(.N_BITS(32), .N_ADDR_BITS(8)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_start          (i_start),
    .i_load_valid     (i_load_valid),
    .i_load_addr      (i_load_addr),
    .i_load_data      (i_load_data),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_jump_direction (i_jump_direction),
    .i_halt           (i_halt),
    .o_instruccion    (o_instruccion),
    .o_pc_4           (o_pc_4),
    .o_pc             (o_pc),
    .o_state          (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    i_load_valid = 1'b1;
    i_load_addr  = addr;
    i_load_data  = data;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic check_if(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] pc);
    check_eq({tag, "_instr"}, o_instruccion, ins);
    check_eq({tag, "_pc4"},   o_pc_4, p4);
    check_eq({tag, "_pc"},    o_pc, pc);
  endtask

  initial begin
    w[0] = 32'h2001_0005; w[1] = 32'h2002_0007; w[2] = 32'h0022_1820; w[3] = 32'hFC00_0000;
    for (int i = 4; i < 10; i++) w[i] = 32'h1000_0000 + 32'(i);
    w[10] = 32'hAAAA_0010;

    i_reset = 1'b0; i_enable = 1'b1; i_start = 1'b0; i_load_valid = 1'b0;
    i_load_addr = 8'h00; i_load_data = 32'h0; i_stall = 1'b0; i_flush = 1'b0;
    i_jump_direction = 32'h0; i_halt = 1'b0;
    tick(); tick();
    check_if("reset", 32'h0, 32'h0, 32'h0);
    check_eq("reset_state", {30'b0, o_state}, 32'h0);
    i_reset = 1'b1;

    for (int i = 0; i < 10; i++) load_word(8'(i), w[i]);
    load_word(8'hFF, 32'hDEAD_00FF);

    // Start edge with a simultaneous load of word 10.
    i_start = 1'b1; i_load_valid = 1'b1; i_load_addr = 8'd10; i_load_data = w[10];
    tick();
    i_start = 1'b0; i_load_valid = 1'b0;
    check_eq("start_state", {30'b0, o_state}, 32'h1);
    check_eq("start_pc", o_pc, 32'h0);

    // Load + run.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("run_instr", o_instruccion, w[i]);
      check_eq("run_pc4", o_pc_4, 32'(4 * (i + 1)));
    end
    for (int i = 0; i < 4; i++) tick();
    check_if("run8", w[7], 32'h20, 32'h20);

    // Reset mid-RUN.
    i_reset = 1'b0; tick(); i_reset = 1'b1;
    check_if("midrst", 32'h0, 32'h0, 32'h0);
    check_eq("midrst_state", {30'b0, o_state}, 32'h0);

    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    check_if("mem_kept", w[0], 32'h4, 32'h4);
    tick();
    check_if("pre_stall", w[1], 32'h8, 32'h8);

    // Stall two cycles, with a load attempt that must be dropped in RUN.
    i_stall = 1'b1; i_load_valid = 1'b1; i_load_addr = 8'd3; i_load_data = 32'h5555_5555;
    tick();
    i_load_valid = 1'b0;
    check_if("stall1", w[1], 32'h8, 32'h8);
    tick();
    check_if("stall2", w[1], 32'h8, 32'h8);
    i_stall = 1'b0;
    tick();
    check_if("post_stall", w[2], 32'hC, 32'hC);

    // Stall beats flush.
    i_stall = 1'b1; i_flush = 1'b1; i_jump_direction = 32'h40;
    tick();
    check_if("stall_flush", w[2], 32'hC, 32'hC);
    i_stall = 1'b0;

    // Enable gating with a flush pending.
    i_enable = 1'b0;
    tick();
    check_if("disabled", w[2], 32'hC, 32'hC);
    check_eq("disabled_state", {30'b0, o_state}, 32'h1);
    i_enable = 1'b1; i_flush = 1'b0;
    tick();
    check_if("run_drop_load", w[3], 32'h10, 32'h10);

    // Flush: one bubble then target.
    i_flush = 1'b1; i_jump_direction = 32'h4;
    tick();
    check_if("flush_bubble", 32'h0, 32'h0, 32'h4);
    i_flush = 1'b0;
    tick();
    check_if("flush_target", w[1], 32'h8, 32'h8);

    // PC wrap at the top of the address space and top memory word.
    i_flush = 1'b1; i_jump_direction = 32'hFFFF_FFFC;
    tick(); i_flush = 1'b0;
    check_eq("wrap_pc", o_pc, 32'hFFFF_FFFC);
    tick();
    check_if("wrap", 32'hDEAD_00FF, 32'h0, 32'h0);
    tick();
    check_if("wrap_next", w[0], 32'h4, 32'h4);

    // High PC bits alias: 0x428 indexes word 10 (written on the start edge).
    i_flush = 1'b1; i_jump_direction = 32'h428;
    tick(); i_flush = 1'b0;
    tick();
    check_if("alias", w[10], 32'h42C, 32'h42C);

    // Halt.
    i_halt = 1'b1;
    tick(); i_halt = 1'b0;
    check_if("halt", 32'h0, 32'h0, 32'h42C);
    check_eq("halt_state", {30'b0, o_state}, 32'h2);
    load_word(8'd0, 32'h1234_5678);
    for (int i = 0; i < 10; i++) tick();
    check_if("halt_frozen", 32'h0, 32'h0, 32'h42C);
    check_eq("halt_frozen_state", {30'b0, o_state}, 32'h2);

    // Reset exits HALTED; halted load must not have landed.
    i_reset = 1'b0; tick(); i_reset = 1'b1;
    check_eq("halt_rst_state", {30'b0, o_state}, 32'h0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    check_if("halt_drop_load", w[0], 32'h4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
